// File: rtl/maindec_mc_if.sv
// Control bundle between the multicycle decoder and the datapath.
// Opcode and memory handshake in; strobes, status and counter out.
interface maindec_mc_if #(parameter int CNT_W = 32);
  logic [10:0]      Op;
  logic             mem_ready;
  logic             Reg2Loc, ALUSrcA, MemtoReg, RegWrite;
  logic             MemRead, MemWrite, IorD, IRWrite;
  logic             PCWrite, Branch, BranchNZ;
  logic [1:0]       ALUSrcB, ALUOp;
  logic             invalid;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Op, mem_ready,
    output Reg2Loc, ALUSrcA, MemtoReg, RegWrite,
    output MemRead, MemWrite, IorD, IRWrite,
    output PCWrite, Branch, BranchNZ,
    output ALUSrcB, ALUOp, invalid, state, instr_count
  );

  modport slave (
    output Op, mem_ready,
    input  Reg2Loc, ALUSrcA, MemtoReg, RegWrite,
    input  MemRead, MemWrite, IorD, IRWrite,
    input  PCWrite, Branch, BranchNZ,
    input  ALUSrcB, ALUOp, invalid, state, instr_count
  );
endinterface

// File: rtl/maindec_mc.sv
// LEGv8 multicycle control FSM: fetch/decode/exec/mem/writeback
// sequencing with memory wait states and a retired-instruction counter.
module maindec_mc #(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_INVALID = 1'b1,
  parameter bit ENABLE_CBNZ     = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  maindec_mc_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ERROR  = 4'd9
  } state_t;

  state_t st, nx;
  logic [CNT_W-1:0] cnt;
  logic ldur, stur, cbz, cbnz, rtype, retire;
  logic r2l, asa, m2r, rw, mrd, mwr;
  logic iord, irw, pcw, br, bnz, inv;
  logic [1:0] asb, aop;

  assign ldur  = bus.Op == 11'b111_1100_0010;
  assign stur  = bus.Op == 11'b111_1100_0000;
  assign cbz   = bus.Op[10:3] == 8'b1011_0100;
  assign cbnz  = ENABLE_CBNZ &&
                 (bus.Op[10:3] == 8'b1011_0101);
  assign rtype = bus.Op inside {
                   11'b100_0101_1000, 11'b110_0101_1000,
                   11'b100_0101_0000, 11'b101_0101_0000};

  // ERROR never retires; a store retires only when its write lands.
  assign retire = (st == MEMWB) || (st == ALUWB) ||
                  (st == BRANCH) ||
                  ((st == MEMWR) && bus.mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st <= nx;
      if (retire) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nx   = FETCH;
    r2l  = 1'b0;
    asa  = 1'b0;
    m2r  = 1'b0;
    rw   = 1'b0;
    mrd  = 1'b0;
    mwr  = 1'b0;
    iord = 1'b0;
    irw  = 1'b0;
    pcw  = 1'b0;
    br   = 1'b0;
    bnz  = 1'b0;
    inv  = 1'b0;
    asb  = 2'b00;
    aop  = 2'b00;
    case (st)
      FETCH: begin
        mrd = 1'b1;
        asb = 2'b01;
        irw = bus.mem_ready;
        pcw = bus.mem_ready;
        nx  = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        asb = 2'b11;
        r2l = stur | cbz | cbnz;
        unique case (1'b1)
          ldur, stur: nx = MEMADR;
          rtype:      nx = EXEC;
          cbz, cbnz:  nx = BRANCH;
          default:    nx = ERROR;
        endcase
      end
      MEMADR: begin
        asa = 1'b1;
        asb = 2'b10;
        r2l = stur;
        nx  = stur ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mrd  = 1'b1;
        iord = 1'b1;
        nx   = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        rw  = 1'b1;
        m2r = 1'b1;
      end
      MEMWR: begin
        mwr  = 1'b1;
        iord = 1'b1;
        r2l  = 1'b1;
        nx   = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        asa = 1'b1;
        aop = 2'b10;
        nx  = ALUWB;
      end
      ALUWB: rw = 1'b1;
      BRANCH: begin
        asa = 1'b1;
        aop = 2'b01;
        r2l = 1'b1;
        br  = 1'b1;
        bnz = cbnz;
      end
      ERROR: begin
        inv = 1'b1;
        nx  = HALT_ON_INVALID ? ERROR : FETCH;
      end
      default: nx = FETCH;
    endcase
  end

  assign bus.Reg2Loc     = r2l;
  assign bus.ALUSrcA     = asa;
  assign bus.MemtoReg    = m2r;
  assign bus.RegWrite    = rw & ~reset;
  assign bus.MemRead     = mrd & ~reset;
  assign bus.MemWrite    = mwr & ~reset;
  assign bus.IorD        = iord;
  assign bus.IRWrite     = irw & ~reset;
  assign bus.PCWrite     = pcw & ~reset;
  assign bus.Branch      = br;
  assign bus.BranchNZ    = bnz;
  assign bus.ALUSrcB     = asb;
  assign bus.ALUOp       = aop;
  assign bus.invalid     = inv;
  assign bus.state       = st;
  assign bus.instr_count = cnt;

endmodule

// File: tb/tb_maindec_mc.sv
// Random-instruction bench for maindec_mc: two parameterisations
// checked cycle by cycle against an instruction-level reference model.
module tb_maindec_mc;

  localparam int LDUR = 0, STUR = 1, CBZ = 2;
  localparam int CBNZ = 3, RT = 4, INV = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel, mr;
  logic [10:0] op;
  logic [31:0] cnt, cmask;
  int n_cmp = 0, n_bad = 0;

  maindec_mc_if #(.CNT_W(32)) ifa ();
  maindec_mc_if #(.CNT_W(4))  ifb ();

  assign ifa.Op = op;
  assign ifa.mem_ready = mr;
  assign ifb.Op = op;
  assign ifb.mem_ready = mr;

  maindec_mc #(
    .CNT_W(32), .HALT_ON_INVALID(1'b1), .ENABLE_CBNZ(1'b1)
  ) dut (.clk(clk), .reset(rst_a), .bus(ifa));

  maindec_mc #(
    .CNT_W(4), .HALT_ON_INVALID(1'b0), .ENABLE_CBNZ(1'b0)
  ) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  logic [14:0] ca, cb, obs_ctrl;
  logic [31:0] obs_cnt;
  logic [3:0]  obs_state;
  logic        obs_inv;

  assign ca = {ifa.Reg2Loc, ifa.ALUSrcA, ifa.MemtoReg,
               ifa.RegWrite, ifa.MemRead, ifa.MemWrite,
               ifa.IorD, ifa.IRWrite, ifa.PCWrite,
               ifa.Branch, ifa.BranchNZ, ifa.ALUSrcB,
               ifa.ALUOp};
  assign cb = {ifb.Reg2Loc, ifb.ALUSrcA, ifb.MemtoReg,
               ifb.RegWrite, ifb.MemRead, ifb.MemWrite,
               ifb.IorD, ifb.IRWrite, ifb.PCWrite,
               ifb.Branch, ifb.BranchNZ, ifb.ALUSrcB,
               ifb.ALUOp};
  assign obs_ctrl  = sel ? cb : ca;
  assign obs_state = sel ? ifb.state : ifa.state;
  assign obs_inv   = sel ? ifb.invalid : ifa.invalid;
  assign obs_cnt   = sel ? {28'd0, ifb.instr_count}
                         : ifa.instr_count;
  assign cmask     = sel ? 32'hf : 32'hffff_ffff;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic int classify(input logic [10:0] o,
                                  input logic en);
    if (o == 11'b11111000010) return LDUR;
    if (o == 11'b11111000000) return STUR;
    if (o[10:3] == 8'b10110100) return CBZ;
    if (o[10:3] == 8'b10110101) return en ? CBNZ : INV;
    if (o == 11'b10001011000 || o == 11'b11001011000 ||
        o == 11'b10001010000 || o == 11'b10101010000)
      return RT;
    return INV;
  endfunction

  function automatic logic [10:0] gen_op(input int k);
    logic [10:0] o;
    logic [2:0]  lo;
    int j;
    lo = 3'($urandom);
    o  = 11'($urandom);
    j  = int'($urandom % 4);
    case (k)
      0: o = 11'b11111000010;
      1: o = 11'b11111000000;
      2: o = {8'b10110100, lo};
      3: o = {8'b10110101, lo};
      4: o = (j == 0) ? 11'b10001011000 :
             (j == 1) ? 11'b11001011000 :
             (j == 2) ? 11'b10001010000 :
                        11'b10101010000;
      default: ;
    endcase
    return o;
  endfunction

  // Expected datapath controls for one cycle of a given state.
  function automatic logic [14:0] exp_ctrl(input int st,
                                           input int cls,
                                           input logic m,
                                           input logic r);
    logic r2l, asa, m2r, rw, mrd, mwr;
    logic iord, irw, pcw, br, bnz;
    logic [1:0] asb, aop;
    {r2l, asa, m2r, rw, mrd, mwr} = '0;
    {iord, irw, pcw, br, bnz} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      0: begin mrd = 1; asb = 2'b01; irw = m; pcw = m; end
      1: begin
        asb = 2'b11;
        r2l = (cls == STUR || cls == CBZ || cls == CBNZ);
      end
      2: begin asa = 1; asb = 2'b10; r2l = (cls == STUR); end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iord = 1; r2l = 1; end
      6: begin asa = 1; aop = 2'b10; end
      7: rw = 1;
      8: begin
        asa = 1; aop = 2'b01; r2l = 1; br = 1;
        bnz = (cls == CBNZ);
      end
      default: ;
    endcase
    if (r) {rw, mrd, mwr, irw, pcw} = '0;
    return {r2l, asa, m2r, rw, mrd, mwr, iord, irw,
            pcw, br, bnz, asb, aop};
  endfunction

  task automatic cyc(input int st, input int cls,
                     input logic m);
    logic r;
    mr = m;
    r  = sel ? rst_b : rst_a;
    @(negedge clk);
    chk("state", 32'(obs_state), 32'(st));
    chk("ctrl", 32'(obs_ctrl), 32'(exp_ctrl(st, cls, m, r)));
    chk("invalid", 32'(obs_inv), (st == 9) ? 32'd1 : 32'd0);
    chk("count", obs_cnt, cnt & cmask);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int cls, input logic [10:0] o,
                           input int wf, input int wm);
    op = o;
    repeat (wf) cyc(0, cls, 1'b0);
    cyc(0, cls, 1'b1);
    cyc(1, cls, rb());
    case (cls)
      LDUR: begin
        cyc(2, cls, rb());
        repeat (wm) cyc(3, cls, 1'b0);
        cyc(3, cls, 1'b1);
        cyc(4, cls, rb());
      end
      STUR: begin
        cyc(2, cls, rb());
        repeat (wm) cyc(5, cls, 1'b0);
        cyc(5, cls, 1'b1);
      end
      CBZ, CBNZ: cyc(8, cls, rb());
      RT: begin
        cyc(6, cls, rb());
        cyc(7, cls, rb());
      end
      default: cyc(9, cls, rb());
    endcase
    if (cls != INV) cnt = cnt + 1;
  endtask

  initial begin
    logic [10:0] o;
    int cls;
    rst_a = 1'b1;
    rst_b = 1'b1;
    sel   = 1'b0;
    mr    = 1'b0;
    op    = 11'd0;
    cnt   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, RT, 1'b1);
    rst_a = 1'b0;

    run_instr(RT, 11'b10001011000, 0, 0);
    chk("add_count", obs_cnt, 32'd1);
    run_instr(LDUR, 11'b11111000010, 2, 1);
    run_instr(STUR, 11'b11111000000, 0, 0);
    run_instr(CBNZ, 11'b10110101101, 0, 0);
    chk("stur_cbnz_count", obs_cnt, 32'd4);

    for (int i = 0; i < 80; i++) begin
      o   = gen_op(int'($urandom % 5));
      cls = classify(o, 1'b1);
      run_instr(cls, o, int'($urandom % 3),
                int'($urandom % 3));
    end

    op = 11'b11111000000;
    cyc(0, STUR, 1'b1);
    cyc(1, STUR, rb());
    cyc(2, STUR, rb());
    rst_a = 1'b1;
    cyc(5, STUR, 1'b0);
    cnt = 32'd0;
    cyc(0, STUR, 1'b0);
    rst_a = 1'b0;

    run_instr(RT, 11'b10101010000, 1, 0);
    op = 11'd0;
    cyc(0, INV, 1'b1);
    cyc(1, INV, rb());
    repeat (20) cyc(9, INV, rb());

    rst_a = 1'b1;
    sel   = 1'b1;
    cnt   = 32'd0;
    @(posedge clk);
    #1;
    rst_b = 1'b0;

    for (int i = 0; i < 16; i++)
      run_instr(RT, gen_op(4), int'($urandom % 2), 0);
    chk("wrap", obs_cnt, 32'd0);

    for (int i = 0; i < 80; i++) begin
      o   = gen_op(int'($urandom % 6));
      cls = classify(o, 1'b0);
      run_instr(cls, o, int'($urandom % 3),
                int'($urandom % 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maindec_mc.md
# maindec_mc

Multicycle control unit for the LEGv8 core. It replaces the single-cycle main decoder with a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It waits on a memory-ready handshake, adds CBNZ next to CBZ, flags invalid opcodes, and counts retired instructions. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `HALT_ON_INVALID`, 1: if 1, an invalid opcode parks the FSM in ERROR until reset; if 0, the instruction is skipped.
- `ENABLE_CBNZ`, 1: if 1, decode CBNZ (`101_1010_1???`); if 0, CBNZ is invalid.
- `clk` in 1: clock; rising edge.
- `reset` in 1: synchronous, active-high.
- `Op` in 11: opcode field from the instruction register, stable from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `Reg2Loc, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, BranchNZ` out 1 each: datapath controls.
- `ALUSrcB` out 2: 00 reg, 01 const 4, 10 D-imm, 11 branch offset <<2.
- `ALUOp` out 2: 00 add, 01 pass-B/zero test, 10 funct-decoded.
- `invalid` out 1: high in ERROR state.
- `state` out 4: current state encoding.
- `instr_count` out CNT_W: instructions retired.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ERROR 9. Codes 10-15 are unreachable and go to FETCH.
- Opcodes: LDUR `111_1100_0010`, STUR `111_1100_0000`, CBZ `101_1010_0???`, CBNZ `101_1010_1???`, ADD `100_0101_1000`, SUB `110_0101_1000`, AND `100_0101_0000`, ORR `101_0101_0000`.
- All outputs not listed for a state are 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00; IRWrite=PCWrite=mem_ready (Mealy).
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00; Reg2Loc=1 for STUR/CBZ/CBNZ.
  - Next state: LDUR/STUR→MEMADR; R-type→EXEC; CBZ/CBNZ→BRANCH; otherwise ERROR.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Reg2Loc=(STUR). LDUR→MEMRD, STUR→MEMWR.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB on mem_ready.
- MEMWB: RegWrite=1, MemtoReg=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1, Reg2Loc=1. Goes to FETCH on mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0. Goes to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, Branch=1, BranchNZ=(CBNZ).
  - The datapath writes PC from ALUOut when the zero test passes. Goes to FETCH.
- ERROR:
  - Outputs: invalid=1, all strobes 0.
  - HALT_ON_INVALID=1: stays in ERROR until reset.
  - HALT_ON_INVALID=0: goes to FETCH after one cycle, with PC already advanced by 4.
- Retire: instr_count increments by 1 on each transition MEMWB→FETCH, MEMWR→FETCH, ALUWB→FETCH or BRANCH→FETCH.
  - It wraps modulo 2^CNT_W.
  - ERROR never retires.

## Timing
- Reset: on a reset edge, state←FETCH and instr_count←0.
  - While reset is high, RegWrite, MemRead, MemWrite, IRWrite and PCWrite are forced 0.
  - Reset asserted mid-instruction aborts it; no retire occurs.
- With mem_ready always 1, cycles per instruction are:
  - CBZ/CBNZ 3.
  - ADD/SUB/AND/ORR 4.
  - STUR 4.
  - LDUR 5.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready outside those states is ignored.
- instr_count updates on the same edge that enters FETCH; it is visible in the first FETCH cycle.
- Wait states do not affect latch outputs; IRWrite/PCWrite pulse only in the mem_ready cycle.

## Test plan
- ADD, mem_ready=1 → state sequence 0,1,6,7,0; RegWrite=1 only in cycle 4; instr_count 0→1.
- LDUR, mem_ready low for 2 cycles in FETCH and 1 in MEMRD → total 8 cycles; IRWrite exactly one pulse; MemtoReg=RegWrite=1 in MEMWB.
- STUR then CBNZ (`10110101xxx`, ENABLE_CBNZ=1) → 4+3 cycles; MemWrite=1 in MEMWR with Reg2Loc=1; BRANCH has Branch=1, BranchNZ=1; count=2.
- Op=`00000000000`:
  - HALT_ON_INVALID=1 → state 9 and invalid=1 held for 20 cycles; count unchanged.
  - HALT_ON_INVALID=0 → returns to FETCH after 1 cycle.
- CNT_W=4, 16 ALU instructions → instr_count wraps to 0.
- reset asserted in MEMWR with mem_ready=0 → next cycle state=0, MemWrite=0, count=0.
